// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload bus between two pipeline stages.
// The master side feeds the stage and drains it; the slave side is the stage itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register: valid/ready handshake, optional
// one-entry skid buffer, stage stall and a per-instance flush (drop or bubble).
module pipe_stage_reg #(
  parameter int                DATA_W          = 64,
  parameter bit                SKID            = 1'b1,
  parameter bit                FLUSH_MODE      = 1'b1,
  parameter logic [DATA_W-1:0] FLUSH_KEEP_MASK = DATA_W'(64'h0000_0000_FFFF_FFFF),
  parameter logic [DATA_W-1:0] FLUSH_VALUE     = '0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             FLUSH,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              main_valid_reg, main_valid_next;
  logic [DATA_W-1:0] main_data_reg,  main_data_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;

  logic              in_ready;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] bubble_data;

  // With the skid entry, in_ready depends only on registered state, never on out_ready.
  generate
    if (SKID) begin : g_ready_skid
      assign in_ready = !skid_valid_reg & !STALL & !FLUSH & !RESET;
    end else begin : g_ready_pass
      assign in_ready = (!main_valid_reg | bus.out_ready) & !STALL & !FLUSH & !RESET;
    end
  endgenerate

  assign in_fire     = bus.in_valid & in_ready;
  assign out_fire    = main_valid_reg & bus.out_ready & !STALL;
  assign bubble_data = (bus.in_data & FLUSH_KEEP_MASK) | (FLUSH_VALUE & ~FLUSH_KEEP_MASK);

  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (STALL) begin
      // frozen: hold everything, flush is lost
    end else if (FLUSH) begin
      // Any out_fire this cycle has already handed main downstream; overwrite after it.
      skid_valid_next = 1'b0;
      if (FLUSH_MODE) begin
        main_valid_next = 1'b1;
        main_data_next  = bubble_data;
      end else begin
        main_valid_next = 1'b0;
      end
    end else begin
      case ({main_valid_reg, skid_valid_reg})
        ST_EMPTY: begin
          if (in_fire) begin
            main_valid_next = 1'b1;
            main_data_next  = bus.in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_next = bus.in_data;
          end else if (in_fire) begin
            if (SKID) begin
              skid_valid_next = 1'b1;
              skid_data_next  = bus.in_data;
            end
          end else if (out_fire) begin
            main_valid_next = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_data_next  = skid_data_reg;
            skid_valid_next = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid_reg;
  assign bus.out_data  = main_data_reg;
  assign occupancy     = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

endmodule
